// File: rtl/fetch_predict_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_predict_unit_if
// Purpose  : Bundle of fetch-side, M-stage and W-stage signals exchanged with
//            the fetch PC predictor/selector.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_predict_unit_if #(
  parameter int ADDR_W = 64
);
  // Fetch-side inputs
  logic              F_stall;
  logic [3:0]        f_icode;
  logic [3:0]        f_ifun;
  logic [ADDR_W-1:0] f_valC;
  logic [ADDR_W-1:0] f_valP;
  // M-stage resolution
  logic [3:0]        M_icode;
  logic [3:0]        M_ifun;
  logic              M_cnd;
  logic              M_pred_taken;
  logic [ADDR_W-1:0] M_PC;
  logic [ADDR_W-1:0] M_valC;
  logic [ADDR_W-1:0] M_valA;
  // W-stage return resolution
  logic [3:0]        W_icode;
  logic [ADDR_W-1:0] W_valM;
  logic [ADDR_W-1:0] W_pred_ret;
  logic              W_ras_hit;
  // Predictor outputs
  logic [ADDR_W-1:0] F_predPC;
  logic [ADDR_W-1:0] f_PC;
  logic              f_pred_taken;
  logic [ADDR_W-1:0] f_pred_ret;
  logic              f_ras_hit;
  logic              redirect;
  logic              ret_stall;

  modport master (
    output F_stall, f_icode, f_ifun, f_valC, f_valP,
    output M_icode, M_ifun, M_cnd, M_pred_taken, M_PC, M_valC, M_valA,
    output W_icode, W_valM, W_pred_ret, W_ras_hit,
    input  F_predPC, f_PC, f_pred_taken, f_pred_ret, f_ras_hit, redirect, ret_stall
  );

  modport slave (
    input  F_stall, f_icode, f_ifun, f_valC, f_valP,
    input  M_icode, M_ifun, M_cnd, M_pred_taken, M_PC, M_valC, M_valA,
    input  W_icode, W_valM, W_pred_ret, W_ras_hit,
    output F_predPC, f_PC, f_pred_taken, f_pred_ret, f_ras_hit, redirect, ret_stall
  );
endinterface
`default_nettype wire

// File: rtl/fetch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_predict_unit
// Purpose  : Fetch-stage PC selector for the pipelined Y86 core: predicted-PC
//            register, bimodal 2-bit BHT for conditional jumps and a circular
//            return address stack, with M/W mispredict recovery.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_predict_unit #(
  parameter int         ADDR_W      = 64,
  parameter int         BHT_ENTRIES = 16,
  parameter int         RAS_DEPTH   = 4,
  parameter logic [1:0] CTR_INIT    = 2'b01
) (
  input  logic                clk,
  input  logic                reset,
  fetch_predict_unit_if.slave bus
);

  localparam int c_idx_w = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;
  localparam int c_ptr_w = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int c_cnt_w = $clog2(RAS_DEPTH + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(RAS_DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(RAS_DEPTH - 1);
  localparam logic [3:0] c_i_jxx  = 4'h7;
  localparam logic [3:0] c_i_call = 4'h8;
  localparam logic [3:0] c_i_ret  = 4'h9;

  logic [ADDR_W-1:0] r_pred_pc;
  logic [1:0]        r_bht [BHT_ENTRIES];
  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
  logic [c_ptr_w-1:0] r_top;
  logic [c_cnt_w-1:0] r_count;

  logic               w_ret_mis;
  logic               w_jmp_mis;
  logic               w_redirect;
  logic [ADDR_W-1:0]  w_f_pc;
  logic               w_bht_taken;
  logic               w_ras_hit;
  logic [ADDR_W-1:0]  w_pred_ret;
  logic               w_pred_taken;
  logic [ADDR_W-1:0]  w_next_pc;
  logic               w_ras_push;
  logic               w_ras_pop;
  logic [c_cnt_w-1:0] w_cnt_base;
  logic [c_ptr_w-1:0] w_top_inc;
  logic [c_ptr_w-1:0] w_top_dec;
  logic               w_m_jcc;
  logic [c_idx_w-1:0] w_m_idx;
  logic [1:0]         w_ctr_old;
  logic [1:0]         w_ctr_new;
  logic               w_unused_bits;

  // Older instruction wins: a W-stage ret mispredict overrides an M-stage jump mispredict
  assign w_ret_mis  = (bus.W_icode == c_i_ret) &&
                      (!bus.W_ras_hit || (bus.W_valM != bus.W_pred_ret));
  assign w_jmp_mis  = (bus.M_icode == c_i_jxx) && (bus.M_ifun != 4'h0) &&
                      (bus.M_cnd != bus.M_pred_taken);
  assign w_redirect = w_ret_mis || w_jmp_mis;

  // Fetch PC selection, redirect target first
  always_comb begin
    w_f_pc = r_pred_pc;
    if (w_ret_mis) begin
      w_f_pc = bus.W_valM;
    end else if (w_jmp_mis) begin
      w_f_pc = bus.M_cnd ? bus.M_valC : bus.M_valA;
    end
  end

  // Prediction lookups use the post-redirect PC; a redirect hides the RAS contents
  assign w_bht_taken = r_bht[w_f_pc[c_idx_w-1:0]][1];
  assign w_ras_hit   = !w_redirect && (r_count != '0);
  assign w_pred_ret  = r_ras[r_top];

  // Taken flag for the instruction at f_PC (unconditional jumps always taken)
  always_comb begin
    w_pred_taken = 1'b0;
    if (bus.f_icode == c_i_jxx) begin
      w_pred_taken = (bus.f_ifun == 4'h0) || w_bht_taken;
    end
  end

  // Next predicted PC from the decoded instruction at f_PC
  always_comb begin
    case (bus.f_icode)
      c_i_call:                w_next_pc = bus.f_valC;
      c_i_jxx:                 w_next_pc = w_pred_taken ? bus.f_valC : bus.f_valP;
      c_i_ret:                 w_next_pc = w_ras_hit ? w_pred_ret : bus.f_valP;
      4'hC, 4'hD, 4'hE, 4'hF:  w_next_pc = '0;
      default:                 w_next_pc = bus.f_valP;
    endcase
  end

  // RAS next-state helpers; the pointer wraps so a push when full overwrites the oldest slot
  always_comb begin
    w_ras_push = !bus.F_stall && (bus.f_icode == c_i_call);
    w_ras_pop  = !bus.F_stall && (bus.f_icode == c_i_ret) && w_ras_hit;
    w_cnt_base = w_redirect ? '0 : r_count;
    w_top_inc  = (r_top == c_ptr_last) ? '0 : r_top + 1'b1;
    w_top_dec  = (r_top == '0) ? c_ptr_last : r_top - 1'b1;
  end

  // Saturating counter update for a resolving conditional jump
  always_comb begin
    w_m_jcc   = (bus.M_icode == c_i_jxx) && (bus.M_ifun != 4'h0);
    w_m_idx   = bus.M_PC[c_idx_w-1:0];
    w_ctr_old = r_bht[w_m_idx];
    if (bus.M_cnd) begin
      w_ctr_new = (w_ctr_old == 2'b11) ? 2'b11 : w_ctr_old + 2'b01;
    end else begin
      w_ctr_new = (w_ctr_old == 2'b00) ? 2'b00 : w_ctr_old - 2'b01;
    end
  end

  // Predicted-PC register and return address stack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pred_pc <= '0;
      r_top     <= '0;
      r_count   <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_ras[i] <= '0;
      end
    end else begin
      if (!bus.F_stall) begin
        r_pred_pc <= w_next_pc;
      end
      r_count <= w_cnt_base;
      if (w_ras_push) begin
        r_ras[w_top_inc] <= bus.f_valP;
        r_top            <= w_top_inc;
        r_count          <= (w_cnt_base == c_cnt_full) ? c_cnt_full : w_cnt_base + 1'b1;
      end else if (w_ras_pop) begin
        r_top   <= w_top_dec;
        r_count <= w_cnt_base - 1'b1;
      end
    end
  end

  // Branch history table, trained from the M stage regardless of fetch stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        r_bht[i] <= CTR_INIT;
      end
    end else if (w_m_jcc) begin
      r_bht[w_m_idx] <= w_ctr_new;
    end
  end

  assign w_unused_bits = ^bus.M_PC[ADDR_W-1:c_idx_w];

  assign bus.F_predPC     = r_pred_pc;
  assign bus.f_PC         = w_f_pc;
  assign bus.f_pred_taken = w_pred_taken;
  assign bus.f_pred_ret   = w_pred_ret;
  assign bus.f_ras_hit    = w_ras_hit;
  assign bus.redirect     = w_redirect;
  assign bus.ret_stall    = (bus.f_icode == c_i_ret) && !w_ras_hit;

endmodule
`default_nettype wire

// File: tb/tb_fetch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_predict_unit
// Purpose  : Self-checking bench for fetch_predict_unit: directed scenarios
//            with literal expectations plus randomized traffic against a
//            queue/array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_predict_unit;

  localparam int c_depth = 4;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  fetch_predict_unit_if #(.ADDR_W(64)) bus();

  fetch_predict_unit #(
    .ADDR_W(64), .BHT_ENTRIES(16), .RAS_DEPTH(c_depth), .CTR_INIT(2'b01)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state: predicted PC, counters, and the RAS as a queue (back = top)
  logic [63:0] m_pred;
  int          m_ctr [16];
  logic [63:0] m_ras [$];

  // Expected outputs for the current cycle
  logic [63:0] e_pc, e_pred_ret, e_next;
  logic        e_redirect, e_hit, e_taken, e_ret_stall;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pred = 64'h0;
    m_ras.delete();
    for (int i = 0; i < 16; i++) m_ctr[i] = 1;
  endtask

  task automatic model_eval();
    logic ret_mis, jmp_mis, bht_taken;
    ret_mis = (bus.W_icode == 4'h9) && (!bus.W_ras_hit || (bus.W_valM != bus.W_pred_ret));
    jmp_mis = (bus.M_icode == 4'h7) && (bus.M_ifun != 4'h0) && (bus.M_cnd != bus.M_pred_taken);
    e_redirect = ret_mis || jmp_mis;
    if (ret_mis)      e_pc = bus.W_valM;
    else if (jmp_mis) e_pc = bus.M_cnd ? bus.M_valC : bus.M_valA;
    else              e_pc = m_pred;
    e_hit      = !e_redirect && (m_ras.size() != 0);
    e_pred_ret = (m_ras.size() != 0) ? m_ras[m_ras.size()-1] : 64'h0;
    bht_taken  = m_ctr[int'(e_pc[3:0])] >= 2;
    e_taken    = (bus.f_icode == 4'h7) && ((bus.f_ifun == 4'h0) || bht_taken);
    e_ret_stall = (bus.f_icode == 4'h9) && !e_hit;
    if (bus.f_icode == 4'h8 || (bus.f_icode == 4'h7 && bus.f_ifun == 4'h0)) e_next = bus.f_valC;
    else if (bus.f_icode == 4'h7) e_next = bht_taken ? bus.f_valC : bus.f_valP;
    else if (bus.f_icode == 4'h9) e_next = e_hit ? e_pred_ret : bus.f_valP;
    else if (bus.f_icode <= 4'hB) e_next = bus.f_valP;
    else e_next = 64'h0;
  endtask

  task automatic model_update();
    int idx;
    if (e_redirect) m_ras.delete();
    if (!bus.F_stall) begin
      if (bus.f_icode == 4'h8) begin
        m_ras.push_back(bus.f_valP);
        if (m_ras.size() > c_depth) void'(m_ras.pop_front());
      end else if (bus.f_icode == 4'h9 && e_hit) begin
        void'(m_ras.pop_back());
      end
      m_pred = e_next;
    end
    if (bus.M_icode == 4'h7 && bus.M_ifun != 4'h0) begin
      idx = int'(bus.M_PC[3:0]);
      if (bus.M_cnd) m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
      else           m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
    end
  endtask

  // Compare every output against the model
  task automatic compare_model();
    model_eval();
    chk("F_predPC",     bus.F_predPC, m_pred);
    chk("f_PC",         bus.f_PC, e_pc);
    chk("redirect",     64'(bus.redirect), 64'(e_redirect));
    chk("f_pred_taken", 64'(bus.f_pred_taken), 64'(e_taken));
    chk("f_ras_hit",    64'(bus.f_ras_hit), 64'(e_hit));
    chk("ret_stall",    64'(bus.ret_stall), 64'(e_ret_stall));
    if (e_hit) chk("f_pred_ret", bus.f_pred_ret, e_pred_ret);
  endtask

  task automatic settle();
    #1;
    compare_model();
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset pulse placed between edges, after settle()
  task automatic async_reset();
    #1 reset = 1'b1;
    #1;
    model_reset();
    compare_model();
    chk("rst_F_predPC", bus.F_predPC, 64'h0);
    chk("rst_f_ras_hit", 64'(bus.f_ras_hit), 64'h0);
    #1 reset = 1'b0;
    #0;
  endtask

  task automatic set_idle();
    bus.F_stall = 1'b0;
    bus.f_icode = 4'h1; bus.f_ifun = 4'h0; bus.f_valC = 64'h0; bus.f_valP = 64'h0;
    bus.M_icode = 4'h1; bus.M_ifun = 4'h0; bus.M_cnd = 1'b0; bus.M_pred_taken = 1'b0;
    bus.M_PC = 64'h0; bus.M_valC = 64'h0; bus.M_valA = 64'h0;
    bus.W_icode = 4'h1; bus.W_valM = 64'h0; bus.W_pred_ret = 64'h0; bus.W_ras_hit = 1'b0;
  endtask

  task automatic set_f(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] vc, input logic [63:0] vp);
    bus.f_icode = ic; bus.f_ifun = fn; bus.f_valC = vc; bus.f_valP = vp;
  endtask

  task automatic set_m(input logic cnd, input logic pred, input logic [63:0] pc,
                       input logic [63:0] vc, input logic [63:0] va);
    bus.M_icode = 4'h7; bus.M_ifun = 4'h1; bus.M_cnd = cnd; bus.M_pred_taken = pred;
    bus.M_PC = pc; bus.M_valC = vc; bus.M_valA = va;
  endtask

  task automatic set_w(input logic [63:0] valm, input logic [63:0] pr, input logic hit);
    bus.W_icode = 4'h9; bus.W_valM = valm; bus.W_pred_ret = pr; bus.W_ras_hit = hit;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    set_idle();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    settle();
    chk("reset_F_predPC", bus.F_predPC, 64'h0);
    chk("reset_f_PC", bus.f_PC, 64'h0);
    chk("reset_f_ras_hit", 64'(bus.f_ras_hit), 64'h0);
    chk("reset_f_pred_ret", bus.f_pred_ret, 64'h0);
    chk("reset_redirect", 64'(bus.redirect), 64'h0);
    tick();

    // Branch learning at 0x20
    set_f(4'h1, 4'h0, 64'h0, 64'h20); settle(); tick();
    set_f(4'h7, 4'h1, 64'h100, 64'h29); settle();
    chk("bl_f_PC", bus.f_PC, 64'h20);
    chk("bl_pred_nt", 64'(bus.f_pred_taken), 64'h0);
    tick();
    set_f(4'h1, 4'h0, 64'h0, 64'h30); settle();
    chk("bl_F_predPC_ft", bus.F_predPC, 64'h29);
    tick();
    set_m(1'b1, 1'b0, 64'h20, 64'h100, 64'h29);
    set_f(4'h1, 4'h0, 64'h0, 64'h20); settle();
    chk("bl_redirect", 64'(bus.redirect), 64'h1);
    chk("bl_redirect_pc", bus.f_PC, 64'h100);
    tick();
    set_idle(); set_f(4'h7, 4'h1, 64'h100, 64'h29); settle();
    chk("bl_f_PC2", bus.f_PC, 64'h20);
    chk("bl_pred_t", 64'(bus.f_pred_taken), 64'h1);
    tick();
    set_f(4'h1, 4'h0, 64'h0, 64'h40); settle();
    chk("bl_F_predPC_tgt", bus.F_predPC, 64'h100);
    tick();

    // Call / return
    set_f(4'h8, 4'h0, 64'h200, 64'h49); settle();
    chk("cr_f_PC", bus.f_PC, 64'h40);
    tick();
    set_f(4'h9, 4'h0, 64'h0, 64'h202); settle();
    chk("cr_F_predPC", bus.F_predPC, 64'h200);
    chk("cr_hit", 64'(bus.f_ras_hit), 64'h1);
    chk("cr_pred_ret", bus.f_pred_ret, 64'h49);
    chk("cr_ret_stall", 64'(bus.ret_stall), 64'h0);
    tick();
    set_w(64'h49, 64'h49, 1'b1); set_f(4'h1, 4'h0, 64'h0, 64'h40); settle();
    chk("cr_ok_redirect", 64'(bus.redirect), 64'h0);
    chk("cr_ok_f_PC", bus.f_PC, 64'h49);
    tick();
    set_idle(); set_f(4'h8, 4'h0, 64'h200, 64'h49); settle(); tick();
    set_f(4'h8, 4'h0, 64'h300, 64'h209); settle(); tick();
    set_f(4'h9, 4'h0, 64'h0, 64'h302); settle();
    chk("cr_nested_ret", bus.f_pred_ret, 64'h209);
    tick();
    set_w(64'h60, 64'h49, 1'b1); set_f(4'h9, 4'h0, 64'h0, 64'h62); settle();
    chk("cr_bad_redirect", 64'(bus.redirect), 64'h1);
    chk("cr_bad_f_PC", bus.f_PC, 64'h60);
    chk("cr_bad_hit", 64'(bus.f_ras_hit), 64'h0);
    chk("cr_bad_ret_stall", 64'(bus.ret_stall), 64'h1);
    tick();
    set_idle(); set_f(4'h9, 4'h0, 64'h0, 64'h64); settle();
    chk("cr_cleared", 64'(bus.f_ras_hit), 64'h0);
    tick();

    // RAS overflow
    for (int k = 1; k <= 5; k++) begin
      set_f(4'h8, 4'h0, 64'h64, 64'(k * 16)); settle(); tick();
    end
    for (int k = 5; k >= 2; k--) begin
      set_f(4'h9, 4'h0, 64'h0, 64'h64); settle();
      chk("ovf_hit", 64'(bus.f_ras_hit), 64'h1);
      chk("ovf_pred_ret", bus.f_pred_ret, 64'(k * 16));
      tick();
    end
    settle();
    chk("ovf_empty_stall", 64'(bus.ret_stall), 64'h1);
    chk("ovf_empty_hit", 64'(bus.f_ras_hit), 64'h0);
    tick();

    // Saturation on index 5
    set_f(4'h1, 4'h0, 64'h0, 64'h5); settle(); tick();
    for (int k = 0; k < 3; k++) begin
      set_idle(); set_f(4'h7, 4'h1, 64'h5, 64'h5); set_m(1'b1, 1'b1, 64'h5, 64'h5, 64'h5);
      settle(); tick();
    end
    set_idle(); set_f(4'h7, 4'h1, 64'h5, 64'h5); settle();
    chk("sat_11", 64'(bus.f_pred_taken), 64'h1);
    tick();
    set_m(1'b0, 1'b0, 64'h5, 64'h5, 64'h5); settle(); tick();
    set_idle(); set_f(4'h7, 4'h1, 64'h5, 64'h5); settle();
    chk("sat_10", 64'(bus.f_pred_taken), 64'h1);
    tick();
    for (int k = 0; k < 4; k++) begin
      set_m(1'b0, 1'b0, 64'h5, 64'h5, 64'h5); settle(); tick();
    end
    set_idle(); set_f(4'h7, 4'h1, 64'h5, 64'h5); settle();
    chk("sat_00", 64'(bus.f_pred_taken), 64'h0);
    tick();

    // Simultaneous W and M mispredicts
    set_f(4'h8, 4'h0, 64'h700, 64'h77); settle(); tick();
    set_w(64'h300, 64'h77, 1'b0); set_m(1'b1, 1'b0, 64'h21, 64'h400, 64'h30);
    set_f(4'h9, 4'h0, 64'h0, 64'h302); settle();
    chk("sim_f_PC", bus.f_PC, 64'h300);
    chk("sim_redirect", 64'(bus.redirect), 64'h1);
    tick();
    set_idle(); set_f(4'h9, 4'h0, 64'h0, 64'h304); settle();
    chk("sim_cleared", 64'(bus.f_ras_hit), 64'h0);
    tick();

    // Stalled call
    set_f(4'h1, 4'h0, 64'h0, 64'h500); settle(); tick();
    bus.F_stall = 1'b1; set_f(4'h8, 4'h0, 64'h600, 64'h509); settle(); tick();
    bus.F_stall = 1'b0; set_f(4'h9, 4'h0, 64'h0, 64'h510); settle();
    chk("stall_F_predPC", bus.F_predPC, 64'h500);
    chk("stall_no_push", 64'(bus.f_ras_hit), 64'h0);
    tick();

    // Reset mid-run: idx 0 counter is 10 and RAS holds one entry beforehand
    set_f(4'h8, 4'h0, 64'h20, 64'h88); settle(); tick();
    set_f(4'h7, 4'h1, 64'h30, 64'h29); settle();
    chk("mid_pre_taken", 64'(bus.f_pred_taken), 64'h1);
    async_reset();
    chk("mid_f_PC", bus.f_PC, 64'h0);
    chk("mid_pred_nt", 64'(bus.f_pred_taken), 64'h0);
    tick();
    set_f(4'h9, 4'h0, 64'h0, 64'h40); settle();
    chk("mid_ras_empty", 64'(bus.f_ras_hit), 64'h0);
    tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 3)      bus.f_icode = 4'h7;
      else if (r < 5) bus.f_icode = 4'h8;
      else if (r < 7) bus.f_icode = 4'h9;
      else            bus.f_icode = 4'($urandom_range(0, 15));
      bus.f_ifun   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 6));
      bus.f_valC   = 64'($urandom_range(0, 255));
      bus.f_valP   = 64'($urandom_range(0, 255));
      bus.F_stall  = ($urandom_range(0, 4) == 0);
      bus.M_icode  = ($urandom_range(0, 2) == 0) ? 4'h1 : 4'h7;
      bus.M_ifun   = 4'($urandom_range(0, 6));
      bus.M_cnd    = 1'($urandom_range(0, 1));
      bus.M_pred_taken = ($urandom_range(0, 3) == 0) ? !bus.M_cnd : bus.M_cnd;
      bus.M_PC     = 64'($urandom_range(0, 63));
      bus.M_valC   = 64'($urandom_range(0, 255));
      bus.M_valA   = 64'($urandom_range(0, 255));
      bus.W_icode  = ($urandom_range(0, 5) == 0) ? 4'h9 : 4'($urandom_range(0, 15));
      bus.W_valM   = 64'($urandom_range(0, 255));
      bus.W_pred_ret = ($urandom_range(0, 9) < 7) ? bus.W_valM : 64'($urandom_range(0, 255));
      bus.W_ras_hit = ($urandom_range(0, 9) < 8);
      settle();
      if ($urandom_range(0, 299) == 0) async_reset();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_predict_unit.md
# fetch_predict_unit

Parametrised fetch-stage PC predictor and selector for the pipelined Y86 core. It combines three functions: predicted-PC register, a bimodal 2-bit branch history table (BHT) for conditional jumps, and a return address stack (RAS) for `ret`. It selects the fetch PC each cycle, applying the mispredict recovery signalled from the M and W stages. It sits between the F pipeline register and instruction memory.

## Interface
- `ADDR_W`, 64: PC/address width.
- `BHT_ENTRIES`, 16: BHT size; power of two, at least 2.
- `RAS_DEPTH`, 4: RAS entries; at least 1.
- `CTR_INIT`, 2'b01: BHT counter reset value (weakly not-taken).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `F_stall`  in  1  hold `F_predPC`; suppress fetch-side RAS push/pop.
- `f_icode`, `f_ifun`  in  4 each  decoded fields of the instruction at `f_PC`.
- `f_valC`, `f_valP`  in  ADDR_W  constant word and fall-through PC.
- `M_icode`, `M_ifun`  in  4 each  M-stage instruction.
- `M_cnd`  in  1  resolved jump condition.
- `M_pred_taken`  in  1  prediction carried down with the jump.
- `M_PC`  in  ADDR_W  jump's own PC, used for the BHT index.
- `M_valC`  in  ADDR_W  jump target.
- `M_valA`  in  ADDR_W  jump fall-through PC.
- `W_icode`  in  4  W-stage instruction.
- `W_valM`  in  ADDR_W  actual return address.
- `W_pred_ret`  in  ADDR_W  predicted return address carried down with the `ret`.
- `W_ras_hit`  in  1  that `ret` was predicted from the RAS.
- `F_predPC`  out  ADDR_W  registered predicted PC.
- `f_PC`  out  ADDR_W  selected fetch PC (combinational).
- `f_pred_taken`  out  1  prediction for the conditional jump at `f_PC`.
- `f_pred_ret`  out  ADDR_W  RAS top; valid when `f_ras_hit`.
- `f_ras_hit`  out  1  RAS supplied the `ret` target.
- `redirect`  out  1  mispredict recovery this cycle.
- `ret_stall`  out  1  a `ret` was fetched with the RAS empty; the control unit must stall as for an unpredicted `ret`.

## Operation
- **Index.** idx(x) = x[log2(BHT_ENTRIES)-1:0]. Taken prediction = counter[idx(f_PC)][1].
- **Redirect priority (older instruction wins):**
  1. W `ret` mispredict: `W_icode`==9 and (`W_ras_hit`==0 or `W_valM`!=`W_pred_ret`). Then `f_PC`=`W_valM`.
  2. Else M conditional-jump mispredict: `M_icode`==7, `M_ifun`!=0, and `M_cnd`!=`M_pred_taken`. Then `f_PC` = `M_cnd` ? `M_valC` : `M_valA`.
  3. Else `f_PC`=`F_predPC`.
  - `redirect` = case 1 or case 2.
- **Next `F_predPC`**, computed from the instruction at `f_PC` and loaded when `F_stall`==0:
  - icode 8 (call), or icode 7 with ifun 0: `f_valC`.
  - icode 7, ifun!=0: `f_valC` if predicted taken, else `f_valP`.
  - icode 9 with `f_ras_hit`: `f_pred_ret`.
  - icode 9 without `f_ras_hit`: `f_valP`, and `ret_stall`=1.
  - Other icodes 0..B: `f_valP`.
  - icode C..F: 0.
- **`f_pred_taken`** = prediction when `f_icode`==7 and `f_ifun`!=0; 1 for an unconditional jump; 0 otherwise.
- **RAS:** circular buffer with top pointer and count (0..RAS_DEPTH).
  - On `redirect`, count is treated as 0 for this cycle's lookup: `f_ras_hit` = !`redirect` and count!=0.
  - Next state starts from (`redirect` ? empty : current). Then, if `F_stall`==0:
    - call pushes `f_valP`. When full, the oldest entry is overwritten and count stays at RAS_DEPTH.
    - `ret` with `f_ras_hit` pops.
  - When `F_stall`==1, only the redirect clear applies.
- **BHT update:** when `M_icode`==7 and `M_ifun`!=0, counter[idx(`M_PC`)] saturating-increments if `M_cnd`, otherwise saturating-decrements (00..11). The update is independent of `F_stall`. The M register never stalls; bubbles carry icode 1.

## Timing
- **Reset** (asynchronous, immediate):
  - `F_predPC`=0, RAS count=0, top pointer=0.
  - All counters = `CTR_INIT`.
  - Resulting outputs: `f_PC`=0 (no redirect), `f_ras_hit`=0, `f_pred_ret`=0, `ret_stall` follows inputs.
- **Reset mid-operation:** all in-flight RAS and BHT state is discarded.
- `f_PC`, `redirect`, `f_pred_*`, `ret_stall` are combinational in the same cycle. `F_predPC` has 1-cycle latency.
- **Same-index BHT read and update in one cycle:** the read sees the old value (no bypass).
- The BHT read uses `f_PC` after redirect selection. The instruction fetched at the redirect target is predicted in the same cycle.

## Test plan
1. **Reset mid-run.** Assert `reset` asynchronously between edges. Required: `F_predPC`=0 immediately, RAS empty, counters 01, so a conditional jump at any PC predicts not-taken.
2. **Branch learning.** Conditional jump at 0x20, `f_valC`=0x100, `f_valP`=0x29. Required: `F_predPC`=0x29. Two cycles later, M presents `M_cnd`=1, `M_pred_taken`=0. Required: `redirect`=1 and `f_PC`=0x100. The counter becomes 10, so the next fetch at 0x20 gives `F_predPC`=0x100.
3. **Saturation.** Three taken updates on one index give 11. One not-taken update gives 10, which still predicts taken. Four not-taken updates give 00.
4. **Call/return.** `call` at 0x40, `f_valC`=0x200, `f_valP`=0x49. Required: `F_predPC`=0x200. A later `ret` gives `f_ras_hit`=1 and `F_predPC`=0x49. W then presents `W_valM`=0x49 with `W_pred_ret`=0x49: `redirect`=0. A second run with `W_valM`=0x60 gives `redirect`=1, `f_PC`=0x60, and the RAS is cleared.
5. **RAS overflow, RAS_DEPTH=4.** Five calls with `f_valP` = 0x10, 0x20, 0x30, 0x40, 0x50, then five rets. Required: the rets predict 0x50, 0x40, 0x30, 0x20, then the fifth ret gives `ret_stall`=1 and `f_ras_hit`=0.
6. **Simultaneous events.**
   - W `ret` mispredict (`W_valM`=0x300) and M jump mispredict in the same cycle. Required: `f_PC`=0x300 and the RAS is cleared.
   - `F_stall`=1 while a call is fetched. Required: `F_predPC` is unchanged and the RAS is not pushed.
